fetch: RTL and testbench

Instruction fetch stage for the RV32I core. It owns the program counter and issues word requests to instruction memory. Returned words are buffered in a small in-order FIFO and presented to the decoder, together with their PC, over a valid/ready handshake. Control-flow redirects from execute flush everything in flight; the first instruction delivered afterwards is the one at the target.

---
 rtl/fetch.sv | 146 ++++++++++++++
 tb/tb_fetch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// rtl/fetch.sv - RV32I fetch stage: PC, credit-gated imem requests, in-order instruction FIFO.
// Optional misaligned-redirect trap marker is enabled by FETCH_MISALIGN_TRAP_EN.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] ins,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic        misaligned
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_RESET, S_RUN, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_RESET, S_RUN} state_t;
`endif

  state_t state, state_nxt;

  logic [31:0]   fpc;
  logic [CW-1:0] cnt, outs, drop, owed;
  logic [CW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] pq_wr, pq_rd;
  logic [31:0]   pq_mem [DEPTH];
  logic [31:0]   fi_ins [DEPTH];
  logic [31:0]   fi_pc  [DEPTH];
  logic [31:0]   hold_ins, hold_pc;
  logic          grant, pop, push, rsp_drop, head_mis, mis_redir, pop_credit;

  // RESET with rst low is the first cycle after release and already fetches.
  assign imem_req   = !rst && !redirect && (state == S_RUN || state == S_RESET) && (cnt < FULL);
  assign imem_addr  = fpc;
  assign grant      = imem_req && imem_gnt;
  assign ins_valid  = (wr_ptr != rd_ptr);
  assign pop        = ins_valid && ins_ready;
  assign rsp_drop   = imem_rvalid && (drop != '0);
  assign push       = imem_rvalid && (drop == '0) && !redirect;
  assign pop_credit = pop && !head_mis;
  assign owed       = outs - CW'(imem_rvalid);

  assign ins  = ins_valid ? fi_ins[rd_ptr[AW-1:0]] : hold_ins;
  assign pc   = ins_valid ? fi_pc[rd_ptr[AW-1:0]]  : hold_pc;
  assign pc_4 = pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fi_mis [DEPTH];
  logic hold_mis;

  assign mis_redir  = redirect && (redirect_pc[1:0] != 2'b00);
  assign head_mis   = fi_mis[rd_ptr[AW-1:0]];
  assign misaligned = ins_valid ? head_mis : hold_mis;

  always_ff @(posedge clk) begin
    if (rst)            hold_mis <= 1'b0;
    else if (ins_valid) hold_mis <= head_mis;
  end

  always_ff @(posedge clk) begin
    if (mis_redir) fi_mis[0] <= 1'b1;
    else if (push) fi_mis[wr_ptr[AW-1:0]] <= 1'b0;
  end
`else
  assign mis_redir  = 1'b0;
  assign head_mis   = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      state_nxt = mis_redir ? S_TRAP : S_RUN;
`else
      state_nxt = S_RUN;
`endif
    end else if (state == S_RESET) begin
      state_nxt = S_RUN;
    end
  end

  // Dropped responses still consume their PC-queue slot to keep pairing in order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RESET;
      fpc      <= RESET_PC;
      cnt      <= '0;
      outs     <= '0;
      drop     <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      pq_wr    <= '0;
      pq_rd    <= '0;
      hold_ins <= '0;
      hold_pc  <= RESET_PC;
    end else begin
      state <= state_nxt;
      outs  <= owed + CW'(grant);
      if (grant)       pq_wr <= pq_wr + AW'(1);
      if (imem_rvalid) pq_rd <= pq_rd + AW'(1);
      if (ins_valid) begin
        hold_ins <= ins;
        hold_pc  <= pc;
      end
      if (redirect) begin
        fpc    <= {redirect_pc[31:2], 2'b00};
        drop   <= owed;
        cnt    <= owed;
        rd_ptr <= '0;
        wr_ptr <= mis_redir ? CW'(1) : '0;
      end else begin
        if (grant)    fpc  <= fpc + 32'd4;
        if (rsp_drop) drop <= drop - CW'(1);
        cnt <= cnt + CW'(grant) - CW'(pop_credit) - CW'(rsp_drop);
        if (push) wr_ptr <= wr_ptr + CW'(1);
        if (pop)  rd_ptr <= rd_ptr + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pq_mem[pq_wr] <= fpc;
    if (mis_redir) begin
      fi_ins[0] <= 32'h0000_0013;
      fi_pc[0]  <= redirect_pc;
    end else if (push) begin
      fi_ins[wr_ptr[AW-1:0]] <= imem_rdata;
      fi_pc[wr_ptr[AW-1:0]]  <= pq_mem[pq_rd];
    end
  end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - directed, table-driven bench for fetch with an in-order imem model.
module tb_fetch;
  logic        clk, rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ins_valid, ins_ready, misaligned;
  logic [31:0] ins, pc, pc_4;

  fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .pc(pc), .pc_4(pc_4),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];

  typedef struct {
    logic        rst_i;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pcv;
    logic [31:0] insv;
  } vec_t;
  vec_t vt[14];

  int total = 0, bad = 0;
  int cyc = 0, lat = 1, npop = 0;
  bit gnt_en = 1, sb_on = 0, g, s_pop, s_rv;
  logic [31:0] exp_pc;
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_ins, s_pc, s_pc4;

  function automatic logic [31:0] w(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: present memory response and grant, sample outputs, then advance.
  task automatic tick();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = w(rq[0].addr);
      void'(rq.pop_front());
    end
    #1;
    imem_gnt = gnt_en;
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = ins_valid; s_ins = ins;
    s_pc = pc; s_pc4 = pc_4; s_mis = misaligned; s_rv = imem_rvalid;
    s_pop = s_valid && ins_ready;
    g = s_req && imem_gnt && !rst;
    if (sb_on && s_pop) begin
      chk("sb_pc", s_pc, exp_pc);
      chk("sb_ins", s_ins, w(exp_pc));
      chk("sb_pc4", s_pc4, exp_pc + 32'd4);
      chk("sb_mis", {31'd0, s_mis}, 32'd0);
      exp_pc = exp_pc + 32'd4;
      npop++;
    end
    @(posedge clk);
    if (rst) rq.delete();
    else if (g) rq.push_back('{s_addr, cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    sb_on = 0;
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    npop = 0;
  endtask

  initial begin
    int grants, stable_bad, idle_bad;
    bit first_g, seen_pc4, seen_addr;
    logic [31:0] prev_ga;

    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
    imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    tick();

    // reset, 1-cycle memory streaming, backpressure, mid-run reset
    vt[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vt[1]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vt[2]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0000_0000};
    vt[3]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'hCAFE_0000};
    vt[4]  = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 32'hCAFE_0004};
    vt[5]  = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'hCAFE_0008};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 32'hCAFE_000C};
    vt[7]  = '{1'b0, 1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 32'hCAFE_000C};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 32'hCAFE_000C};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 32'h1C, 1'b1, 32'h0C, 32'hCAFE_000C};
    vt[10] = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vt[11] = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h0000_0000};
    vt[12] = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 32'h0000_0000};
    vt[13] = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 32'hCAFE_0000};
    for (int i = 0; i < 14; i++) begin
      rst = vt[i].rst_i;
      ins_ready = vt[i].rdy;
      tick();
      chk($sformatf("v%0d_req", i), {31'd0, s_req}, {31'd0, vt[i].req});
      chk($sformatf("v%0d_addr", i), s_addr, vt[i].addr);
      chk($sformatf("v%0d_valid", i), {31'd0, s_valid}, {31'd0, vt[i].vld});
      chk($sformatf("v%0d_pc", i), s_pc, vt[i].pcv);
      chk($sformatf("v%0d_ins", i), s_ins, vt[i].insv);
      chk($sformatf("v%0d_pc4", i), s_pc4, vt[i].pcv + 32'd4);
      chk($sformatf("v%0d_mis", i), {31'd0, s_mis}, 32'd0);
    end

    // ins_ready low for 10 cycles: credits stop at DEPTH, head holds
    lat = 1; ins_ready = 1'b0;
    do_reset();
    grants = 0; stable_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (g) grants++;
      if (i >= 2 && (!s_valid || s_pc !== 32'h0 || s_ins !== w(32'h0))) stable_bad++;
    end
    chk("hold_grants", grants, 4);
    chk("hold_req_off", {31'd0, s_req}, 32'd0);
    chk("hold_stable", stable_bad, 0);
    ins_ready = 1'b1; sb_on = 1; exp_pc = 32'h0; first_g = 0;
    for (int i = 0; i < 30 && npop < 6; i++) begin
      tick();
      if (g && !first_g) begin
        chk("resume_addr", s_addr, 32'h10);
        first_g = 1;
      end
    end
    chk("resume_pops", npop, 6);
    chk("resume_grant_seen", {31'd0, first_g}, 32'd1);

    // latency 3, two outstanding, redirect drops both stale responses
    lat = 3; ins_ready = 1'b1;
    do_reset();
    tick();
    tick();
    gnt_en = 0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    chk("redir_noreq", {31'd0, s_req}, 32'd0);
    redirect = 1'b0; gnt_en = 1; sb_on = 1; exp_pc = 32'h100;
    tick();
    chk("redir_flush", {31'd0, s_valid}, 32'd0);
    chk("redir_addr", s_addr, 32'h100);
    for (int i = 0; i < 40 && npop < 3; i++) tick();
    chk("redir_pops", npop, 3);

    // redirect coinciding with a response and a pop
    lat = 2; ins_ready = 1'b1;
    do_reset();
    sb_on = 1; exp_pc = 32'h0;
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    chk("coinc_rvalid", {31'd0, s_rv}, 32'd1);
    chk("coinc_pop", {31'd0, s_pop}, 32'd1);
    redirect = 1'b0; exp_pc = 32'h80;
    for (int i = 0; i < 40 && npop < 4; i++) tick();
    chk("coinc_pops", npop, 4);

    // address wrap at 0xFFFF_FFFC
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0; exp_pc = 32'hFFFF_FFF8; npop = 0;
    seen_pc4 = 0; seen_addr = 0; prev_ga = 32'h0;
    for (int i = 0; i < 40 && npop < 5; i++) begin
      tick();
      if (s_pop && s_pc == 32'hFFFF_FFFC) begin
        chk("wrap_pc4", s_pc4, 32'h0);
        seen_pc4 = 1;
      end
      if (g) begin
        if (prev_ga == 32'hFFFF_FFFC) begin
          chk("wrap_addr", s_addr, 32'h0);
          seen_addr = 1;
        end
        prev_ga = s_addr;
      end
    end
    chk("wrap_pops", npop, 5);
    chk("wrap_seen", {30'd0, seen_pc4, seen_addr}, 32'd3);

    // misaligned redirect target
    ins_ready = 1'b0; sb_on = 0;
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tick();
    chk("trap_valid", {31'd0, s_valid}, 32'd1);
    chk("trap_ins", s_ins, 32'h13);
    chk("trap_pc", s_pc, 32'h102);
    chk("trap_pc4", s_pc4, 32'h106);
    chk("trap_mis", {31'd0, s_mis}, 32'd1);
    chk("trap_req", {31'd0, s_req}, 32'd0);
    tick();
    chk("trap_hold_pc", s_pc, 32'h102);
    ins_ready = 1'b1;
    tick();
    idle_bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (s_valid || s_req) idle_bad++;
    end
    chk("trap_idle", idle_bad, 0);
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; sb_on = 1; exp_pc = 32'h200; npop = 0;
    for (int i = 0; i < 40 && npop < 2; i++) tick();
    chk("trap_resume_pops", npop, 2);
`else
    tick();
    chk("mis_flush", {31'd0, s_valid}, 32'd0);
    chk("mis_req", {31'd0, s_req}, 32'd1);
    chk("mis_addr", s_addr, 32'h100);
    ins_ready = 1'b1; sb_on = 1; exp_pc = 32'h100; npop = 0;
    idle_bad = 0;
    for (int i = 0; i < 40 && npop < 2; i++) begin
      tick();
      if (s_mis) idle_bad++;
    end
    chk("mis_pops", npop, 2);
    chk("mis_tied", idle_bad, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
